ethernet_config_regs: RTL and testbench
=======================================

// Module: ethernet_config_regs
// PURPOSE
//  MCU-facing SFR bank for the Ethernet config, in the clk_250mhz management domain. Receives byte-wide bus
//  writes, stages multi-byte MAC and IPv4 values in shadow registers, and on commit drives the active values.
//  Each commit produces a one-cycle update strobe (cfgregs.mac_address / ip_config and *_updated) that feeds
//  the downstream per-domain RegisterSynchronizer fan-out.
//  Strobes are rate-limited so the synchronizers are never re-armed mid-handshake.
// PARAMETERS
//  DEFAULT_MAC   48'h02_00_00_00_00_01  active and shadow MAC value after reset
//  HOLDOFF       16                     min cycles between successive strobes of one channel (>=2)
// PORTS
//  clk                  in   1   clk_250mhz management clock
//  rst                  in   1   synchronous, active-high reset
//  wr_en                in   1   bus write strobe, one byte per cycle
//  wr_addr              in   8   write register address
//  wr_data              in   8   write data
//  rd_en                in   1   bus read strobe
//  rd_addr              in   8   read register address
//  rd_data              out  8   read data, valid with rd_valid
//  rd_valid             out  1   one-cycle pulse, 1 cycle after rd_en
//  mac_address          out  48  active MAC address
//  mac_address_updated  out  1   one-cycle pulse, same edge mac_address changes
//  ip_config            out  96  active IPv4Config {address, mask, gateway}
//  ip_config_updated    out  1   one-cycle pulse, same edge ip_config changes
// BEHAVIOUR
//  Interface: one clock domain; reset is synchronous and active-high.
//  Reset: mac_address = shadow = DEFAULT_MAC; ip_config = shadow = 0; strobes, rd_valid, rd_data = 0;
//   pending flags and holdoff counters cleared. Reset mid-holdoff drops any pending commit.
//  Map (byte 0 = MSB): 0x00-0x05 MAC shadow; 0x06 MAC commit (data ignored); 0x10-0x13 IP addr;
//   0x14-0x17 mask; 0x18-0x1B gateway; 0x1C IP commit; 0x1F status (RO).
//   Unmapped writes ignored; unmapped reads return 0x00.
//  Status register: bit0 = mac_pending, bit1 = ip_pending, bits 7:2 = 0.
//  Reads: shadow bytes are returned, not active values. Commit addresses read 0x00.
//   rd_valid/rd_data are registered, latency 1.
//  Per channel (MAC, IP), an identical independent FSM:
//   IDLE: commit write at edge N -> active <= shadow, strobe high in cycle N+1,
//     counter <= HOLDOFF-1, go to HOLD.
//   HOLD: counter decrements each cycle. A commit here sets pending; repeated commits collapse to one.
//     At counter==0: if pending, copy shadow to active at that edge, strobe, reload counter, clear pending,
//     stay in HOLD; else go to IDLE.
//   Shadow writes are accepted in every state. A deferred commit copies the shadow as it is at issue time.
//   Successive strobes on one channel are therefore >= HOLDOFF cycles apart.
//   The MAC and IP channels may strobe in the same cycle.
//  Active outputs change only on strobe edges. Partial shadow writes never leak to the outputs.
// STRUCTURE
//  eth_cfg_pkg: register address localparams (REG_MAC0..REG_STATUS), channel FSM state enum.
//   IPv4Config stays in the existing shared header.
//  Sub-module ethernet_cfg_commit_ctl (WIDTH, HOLDOFF): shadow->active copy, holdoff counter, pending flag,
//   strobe. Instantiated once per channel; the top level does address decode and readback muxing.
// TESTING
//  Reset -> mac_address==DEFAULT_MAC, ip_config==0, no strobes, reads 0x00-0x05 return DEFAULT_MAC bytes.
//  Write 0x00..0x05 = 02 11 22 33 44 55, then commit 0x06 at edge N
//   -> mac_address==48'h021122334455 and mac_address_updated high in cycle N+1 only.
//  Commit IP, then write 0x13=0x07 and commit again 3 cycles later (HOLDOFF=16)
//   -> second strobe exactly 16 cycles after the first, carrying the new byte.
//   Status bit1 reads 1 while pending.
//  Three IP commits inside one holdoff window -> exactly one deferred strobe.
//  MAC and IP commits on consecutive cycles -> independent strobes, no interference. Both strobe together
//   when their holdoffs expire on the same cycle.
//  Assert rst while a commit is pending -> no strobe afterwards; outputs return to reset values.
//   Read 0x0F -> 0x00, rd_valid 1 cycle after rd_en.

Source files
------------

// File: rtl/eth_cfg_pkg.sv
// Shared definitions for the Ethernet config register bank: register map and commit FSM states.
package eth_cfg_pkg;
   localparam logic [7:0] REG_MAC0       = 8'h00;
   localparam logic [7:0] REG_MAC5       = 8'h05;
   localparam logic [7:0] REG_MAC_COMMIT = 8'h06;
   localparam logic [7:0] REG_IP0        = 8'h10;
   localparam logic [7:0] REG_IP11       = 8'h1B;
   localparam logic [7:0] REG_IP_COMMIT  = 8'h1C;
   localparam logic [7:0] REG_STATUS     = 8'h1F;

   localparam int MAC_BYTES = 6;
   localparam int IP_BYTES  = 12;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } cfg_state_e;
endpackage

// File: rtl/ethernet_cfg_commit_ctl.sv
// One config channel: copies shadow to active on commit, with a holdoff window that
// collapses commits arriving too soon into a single deferred strobe.
module ethernet_cfg_commit_ctl
   import eth_cfg_pkg::*;
#(
   parameter int               WIDTH   = 48,
   parameter int               HOLDOFF = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_commit,
   input  logic [WIDTH-1:0] i_shadow,
   output logic [WIDTH-1:0] o_active,
   output logic             o_strobe,
   output logic             o_pending
);
   localparam int CW = $clog2(HOLDOFF);

   cfg_state_e      r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_pend;
   logic            w_fire;
   logic            w_expired;

   assign w_expired = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_commit) begin
               w_fire      = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A commit landing exactly on expiry is served immediately.
            if (w_expired) begin
               if (r_pend || i_commit) w_fire = 1'b1;
               else                    w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_pend   <= 1'b0;
         o_active <= RST_VAL;
         o_strobe <= 1'b0;
      end else begin
         o_strobe <= w_fire;
         if (w_fire) begin
            o_active <= i_shadow;
            r_cnt    <= CW'(HOLDOFF - 1);
            r_pend   <= 1'b0;
         end else if (r_state == ST_HOLD) begin
            if (!w_expired) r_cnt  <= r_cnt - CW'(1);
            if (i_commit)   r_pend <= 1'b1;
         end
      end
   end

   assign o_pending = r_pend;
endmodule

// File: rtl/ethernet_config_regs.sv
// MCU-facing SFR bank for the Ethernet config: byte-wide shadow writes, readback,
// and per-channel commit to the active MAC / IPv4 values.
module ethernet_config_regs
   import eth_cfg_pkg::*;
#(
   parameter logic [47:0] DEFAULT_MAC = 48'h02_00_00_00_00_01,
   parameter int          HOLDOFF     = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_en,
   input  logic [7:0]  i_wr_addr,
   input  logic [7:0]  i_wr_data,
   input  logic        i_rd_en,
   input  logic [7:0]  i_rd_addr,
   output logic [7:0]  o_rd_data,
   output logic        o_rd_valid,
   output logic [47:0] o_mac_address,
   output logic        o_mac_address_updated,
   output logic [95:0] o_ip_config,
   output logic        o_ip_config_updated
);
   logic [47:0] r_mac_sh;
   logic [95:0] r_ip_sh;
   logic        w_mac_commit, w_ip_commit;
   logic        w_mac_pend, w_ip_pend;
   logic [7:0]  w_rd_mux;

   assign w_mac_commit = i_wr_en && (i_wr_addr == REG_MAC_COMMIT);
   assign w_ip_commit  = i_wr_en && (i_wr_addr == REG_IP_COMMIT);

   // Byte 0 of each field is the most significant byte.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mac_sh <= DEFAULT_MAC;
         r_ip_sh  <= '0;
      end else if (i_wr_en) begin
         for (int i = 0; i < MAC_BYTES; i++)
            if (i_wr_addr == REG_MAC0 + 8'(i)) r_mac_sh[(MAC_BYTES-1-i)*8 +: 8] <= i_wr_data;
         for (int i = 0; i < IP_BYTES; i++)
            if (i_wr_addr == REG_IP0 + 8'(i)) r_ip_sh[(IP_BYTES-1-i)*8 +: 8] <= i_wr_data;
      end
   end

   always_comb begin
      w_rd_mux = 8'h00;
      for (int i = 0; i < MAC_BYTES; i++)
         if (i_rd_addr == REG_MAC0 + 8'(i)) w_rd_mux = r_mac_sh[(MAC_BYTES-1-i)*8 +: 8];
      for (int i = 0; i < IP_BYTES; i++)
         if (i_rd_addr == REG_IP0 + 8'(i)) w_rd_mux = r_ip_sh[(IP_BYTES-1-i)*8 +: 8];
      if (i_rd_addr == REG_STATUS) w_rd_mux = {6'b0, w_ip_pend, w_mac_pend};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rd_data  <= 8'h00;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) o_rd_data <= w_rd_mux;
      end
   end

   ethernet_cfg_commit_ctl #(
      .WIDTH   (48),
      .HOLDOFF (HOLDOFF),
      .RST_VAL (DEFAULT_MAC)
   ) u_mac_ctl (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_commit  (w_mac_commit),
      .i_shadow  (r_mac_sh),
      .o_active  (o_mac_address),
      .o_strobe  (o_mac_address_updated),
      .o_pending (w_mac_pend)
   );

   ethernet_cfg_commit_ctl #(
      .WIDTH   (96),
      .HOLDOFF (HOLDOFF),
      .RST_VAL ('0)
   ) u_ip_ctl (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_commit  (w_ip_commit),
      .i_shadow  (r_ip_sh),
      .o_active  (o_ip_config),
      .o_strobe  (o_ip_config_updated),
      .o_pending (w_ip_pend)
   );
endmodule

// File: tb/tb_ethernet_config_regs.sv
// Directed self-checking bench for ethernet_config_regs (HOLDOFF = 16).
module tb_ethernet_config_regs;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = 8'h00;
   logic [7:0]  wr_data = 8'h00;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_addr = 8'h00;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [47:0] mac;
   logic        mac_upd;
   logic [95:0] ip;
   logic        ip_upd;

   localparam logic [47:0] DEF_MAC = 48'h02_00_00_00_00_01;

   ethernet_config_regs #(.DEFAULT_MAC(DEF_MAC), .HOLDOFF(16)) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .i_wr_en               (wr_en),
      .i_wr_addr             (wr_addr),
      .i_wr_data             (wr_data),
      .i_rd_en               (rd_en),
      .i_rd_addr             (rd_addr),
      .o_rd_data             (rd_data),
      .o_rd_valid            (rd_valid),
      .o_mac_address         (mac),
      .o_mac_address_updated (mac_upd),
      .o_ip_config           (ip),
      .o_ip_config_updated   (ip_upd)
   );

   always #2 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ip_seen  = 0, mac_seen = 0;
   int ip_last  = 0, mac_last = 0;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (ip_upd === 1'b1)  begin ip_seen++;  ip_last  = cyc; end
      if (mac_upd === 1'b1) begin mac_seen++; mac_last = cyc; end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic v);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      d = rd_data;
      v = rd_valid;
   endtask

   initial begin
      logic [7:0]  d;
      logic        v;
      logic [47:0] exp_mac;
      int          t1, s0, m0;
      logic [7:0]  mac_bytes [6];
      logic [7:0]  ip_bytes  [12];

      mac_bytes = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      ip_bytes  = '{8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                    8'hC0, 8'hA8, 8'h01, 8'h01};

      // Reset state
      run(3);
      rst = 1'b0;
      chk("rst_mac", 96'(mac), 96'(DEF_MAC));
      chk("rst_ip", ip, 96'h0);
      chk("rst_strobes", {94'h0, mac_upd, ip_upd}, 96'h0);
      chk("rst_rd_valid", 96'(rd_valid), 96'h0);
      exp_mac = DEF_MAC;
      for (int i = 0; i < 6; i++) begin
         rd(8'(i), d, v);
         chk($sformatf("rst_rd_mac%0d", i), {87'h0, v, d}, {87'h0, 1'b1, exp_mac[47-8*i -: 8]});
      end

      // MAC shadow writes then commit
      for (int i = 0; i < 6; i++) wr(8'(i), mac_bytes[i]);
      chk("mac_no_leak", 96'(mac), 96'(DEF_MAC));
      wr(8'h06, 8'hA5);
      chk("mac_commit_val", 96'(mac), 96'h0211_2233_4455);
      chk("mac_strobe_hi", 96'(mac_upd), 96'h1);
      tick();
      chk("mac_strobe_lo", 96'(mac_upd), 96'h0);
      rd(8'h06, d, v);
      chk("rd_commit_addr", 96'(d), 96'h0);

      // IP commit, then a byte change and a second commit 3 cycles later
      for (int i = 0; i < 12; i++) wr(8'h10 + 8'(i), ip_bytes[i]);
      chk("ip_no_leak", ip, 96'h0);
      wr(8'h1C, 8'h00);
      chk("ip_commit_val", ip, 96'hC0A8010A_FFFFFF00_C0A80101);
      chk("ip_strobe_hi", 96'(ip_upd), 96'h1);
      t1 = cyc;
      tick();
      wr(8'h13, 8'h07);
      wr(8'h1C, 8'h00);
      rd(8'h1F, d, v);
      chk("status_ip_pend", 96'(d), 96'h02);
      chk("ip_held", ip, 96'hC0A8010A_FFFFFF00_C0A80101);
      rd(8'h13, d, v);
      chk("rd_ip_shadow", 96'(d), 96'h07);
      for (int k = 0; k < 40 && ip_upd !== 1'b1; k++) tick();
      chk("ip_defer_strobe", 96'(ip_upd), 96'h1);
      chk("ip_defer_gap", 96'(cyc - t1), 96'd16);
      chk("ip_defer_val", ip, 96'hC0A80107_FFFFFF00_C0A80101);
      run(20);

      // Three commits in one window collapse to one deferred strobe
      s0 = ip_seen;
      wr(8'h1C, 8'h00);
      t1 = cyc;
      tick();
      wr(8'h1C, 8'h00);
      tick();
      wr(8'h1C, 8'h00);
      run(40);
      chk("ip_triple_count", 96'(ip_seen - s0), 96'd2);
      chk("ip_triple_gap", 96'(ip_last - t1), 96'd16);

      // MAC and IP on consecutive cycles stay independent
      wr(8'h06, 8'h00);
      chk("indep_mac_hi", {94'h0, mac_upd, ip_upd}, 96'b10);
      wr(8'h1C, 8'h00);
      chk("indep_ip_hi", {94'h0, mac_upd, ip_upd}, 96'b01);
      run(20);

      // IP deferred strobe coincides with a fresh MAC commit
      wr(8'h05, 8'h66);
      wr(8'h1B, 8'h02);
      wr(8'h1C, 8'h00);
      t1 = cyc;
      wr(8'h1C, 8'h00);
      run(t1 + 15 - cyc);
      wr(8'h06, 8'h00);
      chk("both_strobe", {94'h0, mac_upd, ip_upd}, 96'b11);
      chk("both_mac_val", 96'(mac), 96'h0211_2233_4466);
      chk("both_ip_val", ip, 96'hC0A80107_FFFFFF00_C0A80102);
      run(20);

      // Reset with a commit pending drops it
      wr(8'h1C, 8'h00);
      wr(8'h1C, 8'h00);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      s0 = ip_seen;
      m0 = mac_seen;
      run(30);
      chk("rst_drop_ip", 96'(ip_seen - s0), 96'd0);
      chk("rst_drop_mac", 96'(mac_seen - m0), 96'd0);
      chk("rst2_ip", ip, 96'h0);
      chk("rst2_mac", 96'(mac), 96'(DEF_MAC));
      rd(8'h1F, d, v);
      chk("rst2_status", 96'(d), 96'h0);
      rd(8'h00, d, v);
      chk("rst2_shadow", 96'(d), 96'h02);
      rd(8'h0F, d, v);
      chk("unmapped_rd", {87'h0, v, d}, {87'h0, 1'b1, 8'h00});
      tick();
      chk("rd_valid_pulse", 96'(rd_valid), 96'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
